// File: rtl/alu_control_unit_pkg.sv
// Shared state encoding, op codes and control-line indices for the
// sequencer that drives the 8-bit arithmetic unit.
package alu_ctrl_pkg;

  localparam int ITERS    = 8;
  localparam int NUM_CTRL = 11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int C_LDQ   = 0;
  localparam int C_LDM   = 1;
  localparam int C_LDA   = 2;
  localparam int C_SUB   = 3;
  localparam int C_SHIFT = 4;
  localparam int C_INC   = 5;
  localparam int C_SIN   = 6;
  localparam int C_VALID = 7;
  localparam int C_SETQ0 = 8;
  localparam int C_RSV0  = 9;
  localparam int C_RSV1  = 10;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_Q   = 4'd1,
    ST_LD_M   = 4'd2,
    ST_EVAL   = 4'd3,
    ST_SHIFT  = 4'd4,
    ST_DSHIFT = 4'd5,
    ST_DSUB   = 4'd6,
    ST_DFIX   = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

  typedef logic [NUM_CTRL-1:0] ctrl_t;

  // Control lines that depend on the state alone; data-dependent lines are added in the top.
  function automatic ctrl_t moore_ctrl(input state_e st);
    ctrl_t c;
    c = {NUM_CTRL{1'b0}};
    case (st)
      ST_LD_Q:   c[C_LDQ] = 1'b1;
      ST_LD_M:   c[C_LDM] = 1'b1;
      ST_SHIFT: begin
        c[C_SHIFT] = 1'b1;
        c[C_INC]   = 1'b1;
      end
      ST_DSHIFT: c[C_SHIFT] = 1'b1;
      ST_DSUB: begin
        c[C_LDA] = 1'b1;
        c[C_SUB] = 1'b1;
      end
      ST_DFIX:   c[C_INC] = 1'b1;
      ST_DONE:   c[C_VALID] = 1'b1;
      default:   c = {NUM_CTRL{1'b0}};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// Request, status and control-line bundle between the sequencer (master)
// and the requester plus arithmetic unit (slave).
interface alu_control_unit_if;

  logic       start;
  logic [1:0] op;
  logic       q0;
  logic       qm1;
  logic       a_msb;

  logic [1:0] op_o;
  logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
  logic       operand_sel;
  logic       busy;
  logic       done;

  modport master (
    input  start, op, q0, qm1, a_msb,
    output op_o, c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10,
    output operand_sel, busy, done
  );

  modport slave (
    output start, op, q0, qm1, a_msb,
    input  op_o, c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10,
    input  operand_sel, busy, done
  );

endinterface

// File: rtl/alu_control_unit_iter_cnt.sv
// 3-bit iteration counter for the Booth / restoring-division loops;
// flags the final iteration so the sequencer can leave the loop.
module iter_cnt
  import alu_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [2:0] LAST_VAL = 3'(ITERS - 1);

  logic [2:0] value_r;

  // Clear has priority so a new operation always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= 3'd0;
    end else if (clr) begin
      value_r <= 3'd0;
    end else if (inc) begin
      value_r <= value_r + 3'd1;
    end else begin
      value_r <= value_r;
    end
  end

  assign last = (value_r == LAST_VAL);

endmodule

// File: rtl/alu_control_unit.sv
// Sequencer for the 8-bit arithmetic unit: operand loading, Booth multiply,
// restoring divide and the one-cycle completion strobe.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_control_unit_if.master bus
);

  state_e     state_r;
  state_e     state_s;
  logic [1:0] op_r;
  ctrl_t      moore_r;
  logic       busy_r;
  logic       done_r;
  logic       sel_r;

  logic accept_s;
  logic iter_inc_s;
  logic iter_last_s;
  logic booth_add_s;
  logic booth_sub_s;
  logic restore_s;
  logic setq_s;
  logic sin_s;

  assign accept_s   = (state_r == ST_IDLE) && bus.start;
  assign iter_inc_s = (state_r == ST_SHIFT) || (state_r == ST_DFIX);

  iter_cnt u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s),
    .inc  (iter_inc_s),
    .last (iter_last_s)
  );

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = ST_LD_Q;
        else           state_s = ST_IDLE;
      end
      ST_LD_Q: state_s = ST_LD_M;
      ST_LD_M: begin
        case (op_r)
          OP_MUL:  state_s = ST_EVAL;
          OP_DIV:  state_s = ST_DSHIFT;
          default: state_s = ST_DONE;
        endcase
      end
      ST_EVAL: state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (iter_last_s) state_s = ST_DONE;
        else             state_s = ST_EVAL;
      end
      ST_DSHIFT: state_s = ST_DSUB;
      ST_DSUB:   state_s = ST_DFIX;
      ST_DFIX: begin
        if (iter_last_s) state_s = ST_DONE;
        else             state_s = ST_DSHIFT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, latched op and the state-only outputs, registered from the next state
  // so they line up with state_r without a decode stage on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= 2'b00;
      moore_r <= {NUM_CTRL{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sel_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r <= bus.op;
      end else begin
        op_r <= op_r;
      end
      moore_r <= moore_ctrl(state_s);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      sel_r   <= (state_s == ST_LD_M);
    end
  end

  // Lines that follow the datapath status bits within the current cycle.
  always_comb begin
    booth_add_s = 1'b0;
    booth_sub_s = 1'b0;
    restore_s   = 1'b0;
    setq_s      = 1'b0;
    sin_s       = 1'b0;
    case (state_r)
      ST_EVAL: begin
        booth_add_s = ~bus.q0 &  bus.qm1;
        booth_sub_s =  bus.q0 & ~bus.qm1;
      end
      ST_SHIFT: sin_s = bus.a_msb;
      ST_DFIX: begin
        restore_s = bus.a_msb;
        setq_s    = ~bus.a_msb;
      end
      default: begin
        booth_add_s = 1'b0;
        booth_sub_s = 1'b0;
      end
    endcase
  end

  assign bus.op_o        = op_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.operand_sel = sel_r;

  assign bus.c0  = moore_r[C_LDQ];
  assign bus.c1  = moore_r[C_LDM];
  assign bus.c2  = moore_r[C_LDA] | booth_add_s | booth_sub_s | restore_s;
  assign bus.c3  = moore_r[C_SUB] | booth_sub_s;
  assign bus.c4  = moore_r[C_SHIFT];
  assign bus.c5  = moore_r[C_INC];
  assign bus.c6  = moore_r[C_SIN] | sin_s;
  assign bus.c7  = moore_r[C_VALID];
  assign bus.c8  = moore_r[C_SETQ0] | setq_s;
  assign bus.c9  = moore_r[C_RSV0];
  assign bus.c10 = moore_r[C_RSV1];

endmodule

// File: tb/tb_alu_control_unit.sv
// End-to-end bench: sequencer driving a behavioural arithmetic unit, results
// scoreboarded against plain-arithmetic expectations.
module tb_alu_control_unit;
  import alu_ctrl_pkg::*;

  logic clk;
  logic rst;

  alu_control_unit_if bus();

  alu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, required summary");
    $fatal(1, "watchdog expired");
  end

  // Behavioural arithmetic unit: 9-bit A (sign kept), Q, Q-1 and M.
  logic [8:0]  dp_a;
  logic [7:0]  dp_q;
  logic [7:0]  dp_m;
  logic        dp_qm1;
  logic [7:0]  cur_x;
  logic [7:0]  cur_y;
  logic [7:0]  in_bus;
  logic [8:0]  m_ext;
  logic [15:0] z;
  int          cyc;

  assign in_bus    = bus.operand_sel ? cur_y : cur_x;
  assign m_ext     = (bus.op_o == OP_MUL) ? {dp_m[7], dp_m} : {1'b0, dp_m};
  assign bus.q0    = dp_q[0];
  assign bus.qm1   = dp_qm1;
  assign bus.a_msb = dp_a[8];
  assign z = (bus.op_o == OP_ADD) ? {8'h00, dp_q + dp_m} :
             (bus.op_o == OP_SUB) ? {8'h00, dp_q - dp_m} : {dp_a[7:0], dp_q};

  always @(posedge clk) begin
    if (rst) begin
      dp_a   <= 9'd0;
      dp_q   <= 8'd0;
      dp_m   <= 8'd0;
      dp_qm1 <= 1'b0;
    end else begin
      if (bus.c0) begin
        dp_q   <= in_bus;
        dp_a   <= 9'd0;
        dp_qm1 <= 1'b0;
      end
      if (bus.c1) dp_m <= in_bus;
      if (bus.c2) dp_a <= bus.c3 ? dp_a - m_ext : dp_a + m_ext;
      if (bus.c4) begin
        if (bus.op_o == OP_MUL) begin
          dp_a   <= {bus.c6, dp_a[8:1]};
          dp_q   <= {dp_a[0], dp_q[7:1]};
          dp_qm1 <= dp_q[0];
        end else begin
          dp_a <= {dp_a[7:0], dp_q[7]};
          dp_q <= {dp_q[6:0], bus.c6};
        end
      end
      if (bus.c8) dp_q[0] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] z;
    int          lat;
    int          acc;
    int          c8;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_vec();
    return {bus.c10, bus.c9, bus.c8, bus.c7, bus.c6, bus.c5,
            bus.c4, bus.c3, bus.c2, bus.c1, bus.c0};
  endfunction

  // Reference: results straight from integer arithmetic.
  function automatic exp_t make_exp(input logic [1:0] op, input logic [7:0] x,
                                    input logic [7:0] y, input int acc);
    exp_t e;
    int ux, uy, sx, sy;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    e.op  = op;
    e.acc = acc;
    e.c8  = 0;
    case (op)
      OP_ADD: begin e.z = 16'((ux + uy) % 256);       e.lat = 3;  end
      OP_SUB: begin e.z = 16'((ux - uy + 256) % 256); e.lat = 3;  end
      OP_MUL: begin e.z = 16'(sx * sy);               e.lat = 19; end
      default: begin
        e.lat = 27;
        if (uy == 0) begin
          e.z  = 16'(ux * 256 + 255);
          e.c8 = 8;
        end else begin
          e.z  = 16'((ux % uy) * 256 + ux / uy);
          e.c8 = $countones(ux / uy);
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    int   c8_cnt;
    bit   done_prev;
    exp_t e;
    c8_cnt    = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        c8_cnt    = 0;
        done_prev = 1'b0;
      end else begin
        if (!bus.busy) check("idle_quiet", 32'({ctrl_vec(), bus.operand_sel, bus.done}), 32'd0);
        if (bus.c8) c8_cnt++;
        if (bus.done) begin
          check("done_width", 32'(done_prev), 32'd0);
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done with empty scoreboard, required none");
          end else begin
            e = sb_q.pop_front();
            check("result_z", 32'(z), 32'(e.z));
            check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            check("c7_valid", 32'(bus.c7), 32'd1);
            if (e.op == OP_DIV) check("c8_count", 32'(c8_cnt), 32'(e.c8));
          end
          c8_cnt = 0;
        end
        done_prev = bus.done;
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: got busy after 100 cycles, required idle");
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                       input bit track);
    wait_idle();
    cur_x     = x;
    cur_y     = y;
    bus.op    = op;
    bus.start = 1'b1;
    if (track) sb_q.push_back(make_exp(op, x, y, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
  endtask

  initial begin
    int k;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    cur_x     = 8'd0;
    cur_y     = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_op_o", 32'(bus.op_o), 32'd0);
    check("rst_ctrl", 32'({ctrl_vec(), bus.operand_sel}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_ADD, 8'd5, 8'd3, 1'b1);
    issue(OP_SUB, 8'd5, 8'd3, 1'b1);
    issue(OP_MUL, 8'd7, 8'hFD, 1'b1);
    issue(OP_MUL, 8'h80, 8'h80, 1'b1);
    issue(OP_DIV, 8'd100, 8'd7, 1'b1);
    issue(OP_DIV, 8'h5A, 8'h00, 1'b1);

    // start held high through a whole multiply
    wait_idle();
    cur_x     = 8'd3;
    cur_y     = 8'd9;
    bus.op    = OP_MUL;
    bus.start = 1'b1;
    sb_q.push_back(make_exp(OP_MUL, 8'd3, 8'd9, cyc + 1));
    k = 0;
    while (bus.done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("held_start_done", 32'(bus.done), 32'd1);
    sb_q.push_back(make_exp(OP_MUL, 8'd3, 8'd9, cyc + 2));
    @(negedge clk);
    check("reaccept_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("reaccept_ldq", 32'({bus.busy, bus.c0, bus.operand_sel}), 32'b110);
    bus.start = 1'b0;

    // reset in the middle of a multiply
    issue(OP_MUL, 8'd11, 8'd13, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_mul_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_quiet",
          32'({ctrl_vec(), bus.operand_sel, bus.busy, bus.done, bus.op_o}), 32'd0);
    rst = 1'b0;
    issue(OP_DIV, 8'd9, 8'd2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1);
    end

    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
